tl_cntr_n: RTL and testbench
============================

TL_CNTR_N -- requirements
Module: tl_cntr_n

Interface
REQ-001 SHALL have parameter N_ROAD, default 3, number of roads/light heads (legal 2..8).
REQ-002 SHALL have parameter MIN_GREEN, default 4, minimum green length in cycles (>=1).
REQ-003 SHALL have parameter MAX_GREEN, default 16, green length after which a waiting road forces a change (>=MIN_GREEN).
REQ-004 SHALL have parameter YELLOW_CYC, default 2, yellow length in cycles (>=1).
REQ-005 SHALL have parameter ALLRED_CYC, default 1, all-red clearance length in cycles (0 = phase skipped).
REQ-006 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port T  input  N_ROAD  traffic sensors; T[i]=1 means vehicles waiting/present on road i; synchronous to clk.
REQ-009 SHALL have port L  output  2*N_ROAD  light of road i in L[2i+1:2i]: 2'b00 green, 2'b01 yellow, 2'b10 red.
REQ-010 SHALL have port cur_road  output  $clog2(N_ROAD)  index of the road currently owning green/yellow.
REQ-011 SHALL have port phase  output  2  current state: 0 GREEN, 1 YELLOW, 2 ALLRED.

Function
REQ-012 SHALL implement a three-state FSM GREEN -> YELLOW -> ALLRED (or GREEN if ALLRED_CYC=0) -> GREEN.
REQ-013 SHALL keep a cycle timer cleared to 0 on every state entry, incremented each cycle in state, saturating at MAX_GREEN-1.
REQ-014 In GREEN, SHALL drive road cur_road 2'b00 and every other road 2'b10.
REQ-015 In GREEN, SHALL leave for YELLOW at the edge where timer>=MIN_GREEN-1 and (T[cur_road]=0, or timer>=MAX_GREEN-1 and any other T bit is 1).
REQ-016 In GREEN with T[cur_road]=1 and no other T bit set, SHALL stay green indefinitely (timer saturated).
REQ-017 In YELLOW, SHALL drive road cur_road 2'b01, others 2'b10, for exactly YELLOW_CYC cycles.
REQ-018 In ALLRED, SHALL drive all roads 2'b10 for exactly ALLRED_CYC cycles.
REQ-019 On entry to GREEN, SHALL load cur_road with the first index j after cur_road, searched cyclically (cur_road+1 ... cur_road+N_ROAD-1 mod N_ROAD), with T[j]=1.
REQ-020 If no other road has T=1 at that edge, SHALL load cur_road+1 mod N_ROAD (plain rotation, matching the two-road Ta/Tb behaviour).
REQ-021 Next-road selection SHALL use T sampled at the transition edge only; T changes during YELLOW/ALLRED have no other effect.
REQ-022 cur_road wrap-around from N_ROAD-1 SHALL go to 0; non-power-of-two N_ROAD SHALL never produce an index >= N_ROAD.
REQ-023 At no time SHALL more than one road show green or yellow; no road SHALL go green->red without YELLOW_CYC yellow cycles.
REQ-024 L, cur_road, phase SHALL be registered (decoded from state registers, no combinational path from T).

Reset
REQ-025 reset_n=0 SHALL immediately set phase=GREEN, cur_road=0, timer=0, L = road 0 green, all others red (N_ROAD=3: 6'b10_10_00).
REQ-026 Reset asserted mid-YELLOW or mid-ALLRED SHALL abandon the phase with no completion; after release the FSM starts a fresh GREEN on road 0 with full MIN_GREEN.
REQ-027 First state change after reset_n release SHALL occur no earlier than MIN_GREEN rising edges later.

Structure
REQ-028 A shared package tl_pkg SHALL hold light encodings (GREEN/YELLOW/RED) and the phase state encoding.
REQ-029 Cyclic next-road search SHALL be a combinational sub-module rr_next_sel (inputs T, cur_road; output next index).
REQ-030 Timer width SHALL be $clog2(MAX_GREEN) bits minimum; counter compares SHALL be width-safe for all legal parameters.

Verification (N_ROAD=3, MIN_GREEN=4, MAX_GREEN=16, YELLOW_CYC=2, ALLRED_CYC=1)
REQ-031 Reset: reset_n=0, T=3'b000 -> L=6'b10_10_00, cur_road=0, phase=0; release, T=000 -> green 4 cycles, yellow 2, allred 1, then road 1 green.
REQ-032 Skip: cur_road=0, T=3'b100 after min green -> road 0 yellow 2, allred 1, road 2 green (road 1 skipped).
REQ-033 Max green: T=3'b011 held -> road 0 green exactly 16 cycles, then yellow, then road 1 green.
REQ-034 Hold: T=3'b001 held 40 cycles -> road 0 stays green, L constant 6'b10_10_00.
REQ-035 Wrap: cur_road=2, T=3'b001 -> after yellow/allred cur_road=0.
REQ-036 Reset mid-yellow: reset_n=0 at second yellow cycle of road 1 -> L=6'b10_10_00 immediately; after release road 0 green >=4 cycles; assertion checks REQ-023 throughout.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared encodings for the N-road traffic light controller: light codes, phase states, helpers.
package tl_pkg;

    localparam logic [1:0] LIGHT_GREEN  = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_RED    = 2'b10;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Cyclic next-road picker: first road after cur_road with T set, else plain rotation.
module rr_next_sel
    import tl_pkg::*;
#(
    parameter int N_ROAD = 3
) (
    input  logic [N_ROAD-1:0]         T,
    input  logic [$clog2(N_ROAD)-1:0] cur_road,
    output logic [$clog2(N_ROAD)-1:0] next_road
);

    localparam int RW = $clog2(N_ROAD);

    // Walk offsets from farthest to nearest so the nearest requesting road wins.
    always_comb begin
        int idx;
        idx       = 0;
        next_road = (cur_road == RW'(N_ROAD - 1)) ? '0 : cur_road + 1'b1;
        for (int k = N_ROAD - 1; k >= 1; k--) begin
            idx = int'(cur_road) + k;
            if (idx >= N_ROAD) idx = idx - N_ROAD;
            if (T[idx]) next_road = RW'(idx);
        end
    end

endmodule

// File: rtl/tl_cntr_n.sv
// N-road traffic light controller: GREEN -> YELLOW -> ALLRED -> GREEN with demand-driven road choice.
// All outputs are registered and decoded from next state, so T never reaches an output combinationally.
module tl_cntr_n
    import tl_pkg::*;
#(
    parameter int N_ROAD     = 3,
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 16,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_ROAD-1:0]         T,
    output logic [2*N_ROAD-1:0]       L,
    output logic [$clog2(N_ROAD)-1:0] cur_road,
    output logic [1:0]                phase
);

    localparam int RW   = $clog2(N_ROAD);
    // Timer must also cover yellow/allred lengths in case they exceed MAX_GREEN.
    localparam int TCAP = max3(MAX_GREEN, YELLOW_CYC, ALLRED_CYC);
    localparam int TW   = (TCAP > 1) ? $clog2(TCAP) : 1;

    localparam logic [TW-1:0] T_SAT  = TW'(TCAP - 1);
    localparam logic [TW-1:0] T_MING = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_MAXG = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_CYC - 1);
    localparam logic [TW-1:0] T_AR   = TW'(((ALLRED_CYC > 0) ? ALLRED_CYC : 1) - 1);

    localparam logic [2*N_ROAD-1:0] L_RST = {{(N_ROAD-1){LIGHT_RED}}, LIGHT_GREEN};

    phase_e              phase_q, phase_d;
    logic [RW-1:0]       road_q, road_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [2*N_ROAD-1:0] L_q, L_d;

    logic [RW-1:0]       next_road;
    logic [N_ROAD-1:0]   road_mask;
    logic                others_wait;

    rr_next_sel #(.N_ROAD(N_ROAD)) u_sel (
        .T         (T),
        .cur_road  (road_q),
        .next_road (next_road)
    );

    assign road_mask   = {{(N_ROAD-1){1'b0}}, 1'b1} << road_q;
    assign others_wait = |(T & ~road_mask);

    always_comb begin
        phase_d = phase_q;
        road_d  = road_q;
        timer_d = (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;

        unique case (phase_q)
            PH_GREEN: begin
                if (timer_q >= T_MING && (!T[road_q] || (timer_q >= T_MAXG && others_wait))) begin
                    phase_d = PH_YELLOW;
                    timer_d = '0;
                end
            end
            PH_YELLOW: begin
                if (timer_q == T_YEL) begin
                    timer_d = '0;
                    if (ALLRED_CYC == 0) begin
                        phase_d = PH_GREEN;
                        road_d  = next_road;
                    end else begin
                        phase_d = PH_ALLRED;
                    end
                end
            end
            PH_ALLRED: begin
                if (timer_q == T_AR) begin
                    phase_d = PH_GREEN;
                    road_d  = next_road;
                    timer_d = '0;
                end
            end
            default: begin
                phase_d = PH_GREEN;
                road_d  = '0;
                timer_d = '0;
            end
        endcase

        L_d = '0;
        for (int i = 0; i < N_ROAD; i++) L_d[2*i +: 2] = LIGHT_RED;
        if (phase_d != PH_ALLRED)
            L_d[2*int'(road_d) +: 2] = (phase_d == PH_GREEN) ? LIGHT_GREEN : LIGHT_YELLOW;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PH_GREEN;
            road_q  <= '0;
            timer_q <= '0;
            L_q     <= L_RST;
        end else begin
            phase_q <= phase_d;
            road_q  <= road_d;
            timer_q <= timer_d;
            L_q     <= L_d;
        end
    end

    assign L        = L_q;
    assign cur_road = road_q;
    assign phase    = phase_q;

endmodule

// File: tb/tb_tl_cntr_n.sv
// Directed bench for tl_cntr_n with a phase/duration reference model and safety invariants.
module tb_tl_cntr_n;

    localparam int N    = 3;
    localparam int MING = 4;
    localparam int MAXG = 16;
    localparam int YC   = 2;
    localparam int AC   = 1;

    logic           clk     = 1'b0;
    logic           reset_n = 1'b1;
    logic [N-1:0]   T       = '0;
    logic [2*N-1:0] L;
    logic [1:0]     cur_road;
    logic [1:0]     phase;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tl_cntr_n #(
        .N_ROAD(N), .MIN_GREEN(MING), .MAX_GREEN(MAXG), .YELLOW_CYC(YC), .ALLRED_CYC(AC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .T        (T),
        .L        (L),
        .cur_road (cur_road),
        .phase    (phase)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d (b%0b) required=%0d (b%0b) t=%0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: phase kind, owning road, and how many cycles the phase has lasted.
    int m_ph  = 0;
    int m_rd  = 0;
    int m_len = 0;

    function automatic int pick_next(input int r, input logic [N-1:0] t);
        for (int k = 1; k < N; k++)
            if (t[(r + k) % N]) return (r + k) % N;
        return (r + 1) % N;
    endfunction

    function automatic bit others_wait(input int r, input logic [N-1:0] t);
        for (int i = 0; i < N; i++)
            if (i != r && t[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2*N-1:0] exp_L(input int ph, input int rd);
        logic [2*N-1:0] v;
        for (int i = 0; i < N; i++)
            v[2*i +: 2] = (i == rd && ph == 0) ? 2'b00 : (i == rd && ph == 1) ? 2'b01 : 2'b10;
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ph  = 0;
            m_rd  = 0;
            m_len = 0;
        end else begin
            m_len = m_len + 1;
            case (m_ph)
                0: if (m_len >= MING && (!T[m_rd] || (m_len >= MAXG && others_wait(m_rd, T)))) begin
                    m_ph  = 1;
                    m_len = 0;
                end
                1: if (m_len == YC) begin
                    m_len = 0;
                    if (AC == 0) begin
                        m_ph = 0;
                        m_rd = pick_next(m_rd, T);
                    end else begin
                        m_ph = 2;
                    end
                end
                default: if (m_len == AC) begin
                    m_ph  = 0;
                    m_rd  = pick_next(m_rd, T);
                    m_len = 0;
                end
            endcase
        end
    end

    int rst_cnt = 0;
    always @(negedge reset_n) rst_cnt = rst_cnt + 1;

    // Per-cycle compare against the model plus the one-active-head and no-green-to-red rules.
    logic [2*N-1:0] prev_L   = '0;
    int             prev_rst = -1;
    always @(negedge clk) begin
        int active;
        chk("model_L", int'(L), int'(exp_L(m_ph, m_rd)));
        chk("model_road", int'(cur_road), m_rd);
        chk("model_phase", int'(phase), m_ph);
        active = 0;
        for (int i = 0; i < N; i++)
            if (L[2*i +: 2] != 2'b10) active++;
        chk("at_most_one_active", (active > 1) ? 1 : 0, 0);
        if (prev_rst == rst_cnt) begin
            for (int i = 0; i < N; i++)
                chk("no_green_to_red", (prev_L[2*i +: 2] == 2'b00 && L[2*i +: 2] == 2'b10) ? 1 : 0, 0);
        end
        prev_L   = L;
        prev_rst = rst_cnt;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic lit(input string nm, input logic [2*N-1:0] el, input int er, input int ep);
        chk({nm, "_L"}, int'(L), int'(el));
        chk({nm, "_road"}, int'(cur_road), er);
        chk({nm, "_phase"}, int'(phase), ep);
    endtask

    task automatic do_reset(input logic [N-1:0] t_val);
        @(negedge clk);
        #1 reset_n = 1'b0;
        T = t_val;
        #1 lit("reset_now", 6'b10_10_00, 0, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] t;
        int           cyc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // Power-on reset, idle roads: plain rotation through every phase.
        #1 reset_n = 1'b0;
        #1 lit("por", 6'b10_10_00, 0, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        tick(3); lit("idle_min_green", 6'b10_10_00, 0, 0);
        tick(1); lit("idle_yellow",    6'b10_10_01, 0, 1);
        tick(1); lit("idle_yellow2",   6'b10_10_01, 0, 1);
        tick(1); lit("idle_allred",    6'b10_10_10, 0, 2);
        tick(1); lit("idle_road1",     6'b10_00_10, 1, 0);

        // Skip: only road 2 waiting, road 1 is passed over.
        do_reset(3'b100);
        tick(4); lit("skip_yellow", 6'b10_10_01, 0, 1);
        tick(3); lit("skip_road2",  6'b00_10_10, 2, 0);

        // Wrap: from road 2 back to road 0.
        T = 3'b001;
        tick(3); lit("wrap_green",  6'b00_10_10, 2, 0);
        tick(1); lit("wrap_yellow", 6'b01_10_10, 2, 1);
        tick(3); lit("wrap_road0",  6'b10_10_00, 0, 0);

        // Hold: only the green road has demand, it keeps green.
        for (int i = 0; i < 40; i++) begin
            tick(1);
            chk("hold_L", int'(L), int'(6'b10_10_00));
        end

        // Max green: competing demand forces a change after MAX_GREEN cycles.
        do_reset(3'b011);
        tick(15); lit("maxg_still_green", 6'b10_10_00, 0, 0);
        tick(1);  lit("maxg_yellow",      6'b10_10_01, 0, 1);
        tick(3);  lit("maxg_road1",       6'b10_00_10, 1, 0);

        // Reset during the second yellow cycle of road 1.
        T = 3'b000;
        tick(4); lit("ry_yellow1", 6'b10_01_10, 1, 1);
        tick(1); lit("ry_yellow2", 6'b10_01_10, 1, 1);
        #1 reset_n = 1'b0;
        #1 lit("ry_reset", 6'b10_10_00, 0, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        tick(3); lit("ry_fresh_green", 6'b10_10_00, 0, 0);
        tick(1); lit("ry_yellow_after", 6'b10_10_01, 0, 1);

        // Mixed demand patterns, checked by the model every cycle.
        vecs[0] = '{3'b010, 10};
        vecs[1] = '{3'b110, 25};
        vecs[2] = '{3'b111, 40};
        vecs[3] = '{3'b000, 12};
        vecs[4] = '{3'b101, 30};
        vecs[5] = '{3'b100, 8};
        foreach (vecs[i]) begin
            T = vecs[i].t;
            tick(vecs[i].cyc);
        end

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
